// File: rtl/mbinit_seq_param.sv
// Mainband-initialisation sequencer: sideband handshake, lane test, half-width repair
// and a saturating per-state timeout. Outputs are registered from the next state.
module mbinit_seq_param #(
    parameter int unsigned NUM_LANES   = 16,
    parameter int unsigned TIMEOUT_CYC = 800000,
    parameter bit          REPAIR_EN   = 1'b1
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 enable_i,
    output logic [7:0]           tx_msg_o,
    output logic [NUM_LANES-1:0] tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    input  logic [7:0]           rx_msg_i,
    input  logic [NUM_LANES-1:0] rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    output logic                 lane_test_start_o,
    input  logic                 lane_test_done_i,
    input  logic [NUM_LANES-1:0] lane_fail_i,
    output logic [NUM_LANES-1:0] active_lanes_o,
    output logic                 mbinit_done_o,
    output logic                 mbinit_error_o
);

    localparam int unsigned HALF  = NUM_LANES / 2;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]     CNT_SAT    = CNT_W'(TIMEOUT_CYC);
    localparam logic [NUM_LANES-1:0] ALL_ONES   = '1;
    localparam logic [NUM_LANES-1:0] LOWER_MASK = {{HALF{1'b0}}, {HALF{1'b1}}};
    localparam logic [NUM_LANES-1:0] UPPER_MASK = {{HALF{1'b1}}, {HALF{1'b0}}};

    localparam logic [7:0] PARAM_REQ  = 8'h01;
    localparam logic [7:0] PARAM_RSP  = 8'h02;
    localparam logic [7:0] CAL_REQ    = 8'h03;
    localparam logic [7:0] CAL_RSP    = 8'h04;
    localparam logic [7:0] RESULT_REQ = 8'h05;
    localparam logic [7:0] RESULT_RSP = 8'h06;
    localparam logic [7:0] APPLY_REQ  = 8'h07;
    localparam logic [7:0] APPLY_RSP  = 8'h08;

    typedef enum logic [3:0] {
        IDLE, PARAM_TX, PARAM_WAIT, CAL_TX, CAL_WAIT, TEST_RUN,
        RESULT_TX, RESULT_WAIT, APPLY_TX, APPLY_WAIT, DONE, ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LANES-1:0] local_fail_q, local_fail_d;
    logic [NUM_LANES-1:0] cand_q, cand_d;
    logic [NUM_LANES-1:0] active_q, active_d;
    logic [7:0]           tx_msg_q, tx_msg_d;
    logic [NUM_LANES-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [NUM_LANES-1:0] good;
    logic                 rx_hit;
    logic                 timed;

    // Next-state, latched vectors and next-cycle output values
    always_comb begin
        state_d      = state_q;
        local_fail_d = local_fail_q;
        cand_d       = cand_q;
        active_d     = active_q;
        tx_msg_d     = 8'h00;
        tx_data_d    = '0;
        tx_valid_d   = 1'b0;
        rx_ready_d   = 1'b0;
        start_d      = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        good         = ~local_fail_q & rx_data_i;
        rx_hit       = rx_valid_i && rx_ready_q;
        timed        = !(state_q inside {IDLE, DONE, ERROR});

        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:        state_d = PARAM_TX;
                PARAM_TX:    if (tx_ready_i) state_d = PARAM_WAIT;
                PARAM_WAIT:  if (rx_hit && rx_msg_i == PARAM_RSP) state_d = CAL_TX;
                CAL_TX:      if (tx_ready_i) state_d = CAL_WAIT;
                CAL_WAIT:    if (rx_hit && rx_msg_i == CAL_RSP) state_d = TEST_RUN;
                TEST_RUN: begin
                    if (lane_test_done_i) begin
                        local_fail_d = lane_fail_i;
                        state_d      = RESULT_TX;
                    end
                end
                RESULT_TX:   if (tx_ready_i) state_d = RESULT_WAIT;
                RESULT_WAIT: begin
                    if (rx_hit && rx_msg_i == RESULT_RSP) begin
                        if (good == ALL_ONES) begin
                            cand_d  = ALL_ONES;
                            state_d = APPLY_TX;
                        end else if (REPAIR_EN && good[HALF-1:0] == LOWER_MASK[HALF-1:0]) begin
                            cand_d  = LOWER_MASK;
                            state_d = APPLY_TX;
                        end else if (REPAIR_EN && good[NUM_LANES-1:HALF] == UPPER_MASK[NUM_LANES-1:HALF]) begin
                            cand_d  = UPPER_MASK;
                            state_d = APPLY_TX;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                end
                APPLY_TX:    if (tx_ready_i) state_d = APPLY_WAIT;
                APPLY_WAIT: begin
                    if (rx_hit && rx_msg_i == APPLY_RSP) begin
                        if (rx_data_i == cand_q) begin
                            active_d = cand_q;
                            state_d  = DONE;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                end
                DONE:        state_d = DONE;
                ERROR:       state_d = ERROR;
                default:     state_d = ERROR;
            endcase

            // An advancing handshake on the expiry edge takes priority over the timeout
            if (timed && state_d == state_q && cnt_q == CNT_LAST) state_d = ERROR;
        end

        cnt_d = (state_d != state_q) ? '0 :
                (cnt_q == CNT_SAT)   ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_d)
            IDLE: begin
                active_d     = '0;
                cand_d       = '0;
                local_fail_d = '0;
            end
            PARAM_TX: begin
                tx_valid_d = 1'b1;
                tx_msg_d   = PARAM_REQ;
                tx_data_d  = ALL_ONES;
            end
            CAL_TX: begin
                tx_valid_d = 1'b1;
                tx_msg_d   = CAL_REQ;
                tx_data_d  = ALL_ONES;
            end
            RESULT_TX: begin
                tx_valid_d = 1'b1;
                tx_msg_d   = RESULT_REQ;
                tx_data_d  = ~local_fail_d;
            end
            APPLY_TX: begin
                tx_valid_d = 1'b1;
                tx_msg_d   = APPLY_REQ;
                tx_data_d  = cand_d;
            end
            PARAM_WAIT, CAL_WAIT, RESULT_WAIT, APPLY_WAIT: rx_ready_d = 1'b1;
            TEST_RUN:    start_d = (state_q != TEST_RUN);
            DONE:        done_d  = 1'b1;
            ERROR:       error_d = 1'b1;
            default:     error_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            local_fail_q <= '0;
            cand_q       <= '0;
            active_q     <= '0;
            tx_msg_q     <= 8'h00;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            rx_ready_q   <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            local_fail_q <= local_fail_d;
            cand_q       <= cand_d;
            active_q     <= active_d;
            tx_msg_q     <= tx_msg_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            rx_ready_q   <= rx_ready_d;
            start_q      <= start_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign tx_msg_o          = tx_msg_q;
    assign tx_data_o         = tx_data_q;
    assign tx_valid_o        = tx_valid_q;
    assign rx_ready_o        = rx_ready_q;
    assign lane_test_start_o = start_q;
    assign active_lanes_o    = active_q;
    assign mbinit_done_o     = done_q;
    assign mbinit_error_o    = error_q;

endmodule

// File: doc/mbinit_seq_param.md
# mbinit_seq_param

Parametrised mainband-initialisation sequencer for the UCIe logical PHY LTSM. It runs the MBINIT handshake with the link partner over the sideband (param exchange, calibration, per-lane test, lane-map apply) and drives the lane-test engine. It adds a per-state timeout, lane-count generalisation and half-width lane repair, then reports the agreed active-lane mask to the LTSM.

## Interface
Parameters:
- NUM_LANES, 16: mainband data lanes; even, ≥2.
- TIMEOUT_CYC, 800000: cycles allowed per waiting state; 8 ms at 100 MHz.
- REPAIR_EN, 1: 1 allows degrade to lower or upper half; 0 means any lane failure → ERROR.

Ports (name, direction, width, meaning):
- clk_100MHz, in, 1: sole clock.
- reset, in, 1: asynchronous, active-low reset.
- enable_i, in, 1: LTSM grants MBINIT; low aborts to IDLE.
- tx_msg_o, out, 8: sideband message code.
- tx_data_o, out, NUM_LANES: message payload.
- tx_valid_o, out, 1: message valid.
- tx_ready_i, in, 1: sideband TX accepts.
- rx_msg_i, in, 8: received code.
- rx_data_i, in, NUM_LANES: received payload.
- rx_valid_i, in, 1: received message valid.
- rx_ready_o, out, 1: consume received message.
- lane_test_start_o, out, 1: one-cycle pulse that starts the pattern test.
- lane_test_done_i, in, 1: test complete (level or pulse).
- lane_fail_i, in, NUM_LANES: per-lane fail, valid while lane_test_done_i=1.
- active_lanes_o, out, NUM_LANES: agreed lane mask.
- mbinit_done_o, out, 1: sequence passed.
- mbinit_error_o, out, 1: sequence failed.

## Operation
- Message codes: PARAM_REQ 0x01, PARAM_RSP 0x02, CAL_REQ 0x03, CAL_RSP 0x04, RESULT_REQ 0x05, RESULT_RSP 0x06, APPLY_REQ 0x07, APPLY_RSP 0x08.
- States: IDLE, PARAM_TX, PARAM_WAIT, CAL_TX, CAL_WAIT, TEST_RUN, RESULT_TX, RESULT_WAIT, APPLY_TX, APPLY_WAIT, DONE, ERROR.
- IDLE:
  - enable_i=1 → PARAM_TX.
  - All outputs are 0. The active-lane mask is cleared.
- *_TX states:
  - tx_valid_o=1 with a stable code and payload until tx_ready_i=1, then → the matching *_WAIT.
  - PARAM and CAL payload is all-ones.
  - RESULT payload = ~local_fail.
  - APPLY payload = candidate mask.
- *_WAIT states:
  - rx_ready_o=1.
  - A message with the expected code advances the state.
  - Any other code is consumed and ignored, and the timer keeps running.
- PARAM_WAIT → CAL_TX. CAL_WAIT → TEST_RUN.
- TEST_RUN:
  - Pulse lane_test_start_o on the first cycle.
  - Wait for lane_test_done_i. Latch local_fail = lane_fail_i. Go to RESULT_TX.
- RESULT_WAIT:
  - Capture remote_good = rx_data_i and form good = ~local_fail & remote_good.
  - If good is all-ones, the candidate is all-ones.
  - Else, if REPAIR_EN and the lower half good[NUM_LANES/2-1:0] is all-ones, the candidate is the lower-half mask.
  - Else, if REPAIR_EN and the upper half is all-ones, the candidate is the upper-half mask.
  - Otherwise → ERROR. With a valid candidate → APPLY_TX.
- APPLY_WAIT:
  - rx_data_i equal to the candidate → DONE; active_lanes_o = candidate.
  - rx_data_i different → ERROR.
- DONE and ERROR hold their flag until enable_i=0.
- Timeout:
  - A counter clears on every state entry.
  - In any *_TX, *_WAIT or TEST_RUN state, reaching TIMEOUT_CYC-1 → ERROR.
  - Counter width is $clog2(TIMEOUT_CYC+1); it saturates and never wraps.
- enable_i=0 in any state → IDLE on the next edge. All outputs clear, and any pending TX is dropped (tx_valid_o falls).

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; latched vectors 0.
- All outputs are registered.
- enable_i rising at edge N → tx_valid_o=1 with code 0x01 after edge N+1.
- A TX handshake accepted at edge N puts the FSM in *_WAIT from edge N. rx_ready_o is high from that cycle.
- The expected RX is accepted at edge N. The next *_TX asserts tx_valid_o after edge N.
- If tx_ready_i is already high, one message per state completes in one cycle.
- lane_test_start_o is high exactly one cycle after entering TEST_RUN. A lane_test_done_i in that same cycle is honoured.
- Timeout and expected message on the same edge: the message wins.
- enable_i=0 and any other event on the same edge: abort wins.
- mbinit_done_o and active_lanes_o update on the same edge.

## Test plan
- Clean link, NUM_LANES=16, partner replies immediately, lane_fail_i=0:
  - Required: messages 0x01, 0x03, 0x05 (payload 0xFFFF), 0x07 (0xFFFF).
  - Then mbinit_done_o=1 and active_lanes_o=0xFFFF.
- lane_fail_i=0x0100 and remote_good=0xFFFF, REPAIR_EN=1:
  - Required: APPLY payload 0x00FF; partner echoes it; done with active_lanes_o=0x00FF.
- Degrade rejected:
  - Local fail 0x0001 with remote_good=0x7FFF → ERROR (both halves bad).
  - REPAIR_EN=0 with any single-lane fail → ERROR.
- Timeout, TIMEOUT_CYC=100: partner never answers CAL_REQ.
  - Required: mbinit_error_o rises exactly 100 cycles after CAL_WAIT entry.
  - A stray 0x06 received during CAL_WAIT is consumed and ignored.
- Abort and reset mid-sequence:
  - enable_i drops while tx_valid_o=1 and tx_ready_i=0 → next cycle tx_valid_o=0, state IDLE.
  - Re-enable → a clean sequence completes.
  - Async reset asserted mid-RESULT_WAIT → all outputs 0 immediately.
- APPLY_RSP payload mismatch (0x00FF sent, 0xFF00 received) → ERROR, active_lanes_o stays 0.
